fpga_row_cfg_loader: RTL
========================

Name: fpga_row_cfg_loader

Overview:
Configuration controller for one FPGA row. It receives a word-serial configuration stream over a valid/ready handshake and assembles it into a shadow register. It then verifies an XOR checksum and atomically commits the routing-block, switch-block and logic-block select vectors that drive the row. The row fabric never sees a partially loaded or corrupted configuration.

Parameters:
wire_width, 3, routing channel width per block edge
fpga_width, 5, number of routing blocks in the row
DATA_WIDTH, 32, config stream word width in bits

Derived constants:
- BRB_BITS = fpga_width*wire_width*12
- BSB_BITS = (fpga_width-1)*wire_width*wire_width*12
- LB_BITS = (fpga_width-1)*5
- CFG_BITS = BRB_BITS+BSB_BITS+LB_BITS
- NWORDS = ceil(CFG_BITS/DATA_WIDTH)
- Defaults: CFG_BITS=632, NWORDS=20

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  pulse: begin a new load (honoured only in IDLE, DONE or ERROR)
abort  in  1  pulse: discard the load in progress, return to IDLE
in_data  in  DATA_WIDTH  stream word
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a word this cycle
busy  out  1  high in LOAD, CHECK or COMMIT
cfg_done  out  1  one-cycle pulse, aligned with the commit of new select outputs
cfg_err  out  1  sticky checksum-mismatch flag
brbselect  out  BRB_BITS  active routing-block select vector
bsbselect  out  BSB_BITS  active switch-block select vector
lbselect  out  LB_BITS  active logic-block config vector

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - All select outputs, shadow register, word counter and checksum accumulator cleared to 0.
  - in_ready=0, busy=0, cfg_done=0, cfg_err=0.
- States: IDLE, LOAD, CHECK, COMMIT, DONE, ERROR.
- IDLE/DONE/ERROR + start=1 -> LOAD:
  - word counter=0, accumulator=0, cfg_err cleared.
  - The shadow register is not cleared; every bit is overwritten during LOAD.
- start is ignored while busy.
- in_ready=1 only in LOAD and CHECK. A beat transfers when in_valid && in_ready at a rising edge.
- LOAD:
  - Word k is written to shadow[k*DATA_WIDTH +: DATA_WIDTH], truncated to CFG_BITS for the last word; unused upper bits of the last word are dropped.
  - accumulator ^= the full in_data word.
  - After word NWORDS-1 transfers -> CHECK.
- Shadow bit mapping: shadow = {lbselect, bsbselect, brbselect}, so bit 0 is brbselect[0].
- CHECK:
  - One beat, the checksum word, is transferred.
  - If it equals the accumulator -> COMMIT; otherwise -> ERROR.
- COMMIT (lasts one cycle, in_ready=0):
  - At the end of the cycle, all three select outputs load from shadow simultaneously and cfg_done=1 for the following cycle.
  - State -> DONE.
- Latency: new outputs and cfg_done become visible 2 cycles after the checksum handshake cycle.
- ERROR: cfg_err=1 until the next start or reset; select outputs keep their previous committed values.
- abort=1 in LOAD or CHECK -> IDLE next cycle. No transfer is counted that cycle, and outputs are unchanged.
- abort in COMMIT is ignored; the commit completes.
- abort has priority over a simultaneous beat.
- Reset mid-load or mid-commit: all outputs return to 0 and the partial load is lost.
- in_valid=0 stalls the load indefinitely; there is no timeout.

Decomposition:
- Shared package fpga_cfg_pkg holds the derived constants BRB_BITS, BSB_BITS, LB_BITS, CFG_BITS and NWORDS, plus the state enum, so that fpga_row and top-level loaders agree on the packing.
- One natural sub-module, cfg_xor_accum: the word-wide XOR accumulator with clear and enable inputs.

Test Plan:
- Load 20 words of 0x00000000 followed by checksum 0x00000000 -> cfg_done pulses once 2 cycles after the checksum beat; all selects are 0; cfg_err=0.
- Load word k = k+1 (k=0..19), checksum = XOR of 1..20 = 0x00000014 -> brbselect[31:0]=0x00000001; lbselect[19:0] = bits [631:612] of shadow (taken from word 19 = 0x14); cfg_done asserts.
- Same load with checksum 0x00000015 -> cfg_err=1, no cfg_done; selects keep the prior committed values.
- Toggle in_valid every other cycle during a load -> only handshaked beats count; the result matches the contiguous load.
- abort after 7 words, then start and a full valid load -> IDLE without an output change, then a correct commit; cfg_err stays 0.
- Assert rst_n=0 during the COMMIT cycle -> selects are 0 and state is IDLE next cycle; cfg_done is never asserted.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared row-configuration packing constants and loader state type
//
// Purpose: single source for the select-vector sizes so every row loader and
//          the row fabric agree on how the configuration image is packed.
// Ports:   none (package).

package fpga_cfg_pkg;

   function automatic int brb_bits_f(input int ww, input int fw);
      return fw * ww * 12;
   endfunction

   function automatic int bsb_bits_f(input int ww, input int fw);
      return (fw - 1) * ww * ww * 12;
   endfunction

   function automatic int lb_bits_f(input int fw);
      return (fw - 1) * 5;
   endfunction

   function automatic int cfg_bits_f(input int ww, input int fw);
      return brb_bits_f(ww, fw) + bsb_bits_f(ww, fw) + lb_bits_f(fw);
   endfunction

   function automatic int nwords_f(input int ww, input int fw, input int dw);
      return (cfg_bits_f(ww, fw) + dw - 1) / dw;
   endfunction

   localparam int WIRE_WIDTH = 3;
   localparam int FPGA_WIDTH = 5;
   localparam int CFG_DW     = 32;

   localparam int BRB_BITS = brb_bits_f(WIRE_WIDTH, FPGA_WIDTH);
   localparam int BSB_BITS = bsb_bits_f(WIRE_WIDTH, FPGA_WIDTH);
   localparam int LB_BITS  = lb_bits_f(FPGA_WIDTH);
   localparam int CFG_BITS = cfg_bits_f(WIRE_WIDTH, FPGA_WIDTH);
   localparam int NWORDS   = nwords_f(WIRE_WIDTH, FPGA_WIDTH, CFG_DW);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CHECK  = 3'd2,
      S_COMMIT = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } cfg_state_t;

endpackage

// File: rtl/fpga_row_cfg_loader_if.sv
// rtl/fpga_row_cfg_loader_if.sv - word-serial configuration stream interface
//
// Purpose: valid/ready stream carrying configuration words into the loader.
// Signals: in_data  - stream word
//          in_valid - in_data valid (driven by master)
//          in_ready - loader accepts a word this cycle (driven by slave)

interface fpga_row_cfg_loader_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/cfg_xor_accum.sv
// rtl/cfg_xor_accum.sv - word-wide XOR checksum accumulator
//
// Purpose: running XOR of accepted configuration words.
// Ports:   clk, rst_n - clock and synchronous active-low reset
//          clr        - zero the accumulator (wins over en)
//          en         - fold d into the accumulator
//          d          - word to fold in
//          acc        - current accumulator value

module cfg_xor_accum #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] acc
);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc ^ d;
      end
   end

endmodule

// File: rtl/fpga_row_cfg_loader.sv
// rtl/fpga_row_cfg_loader.sv - checksummed, atomic configuration loader for one FPGA row
//
// Purpose: assembles NWORDS stream words into a shadow image, verifies an XOR
//          checksum word, then commits all select vectors in one cycle.
// Ports:   clk, rst_n          - clock, synchronous active-low reset
//          start, abort        - begin a load / discard the load in progress
//          cfg                 - slave side of the configuration stream
//          busy                - high in LOAD, CHECK, COMMIT
//          cfg_done            - one-cycle pulse aligned with new select outputs
//          cfg_err             - sticky checksum-mismatch flag
//          brbselect/bsbselect/lbselect - committed select vectors

module fpga_row_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int wire_width = 3,
   parameter int fpga_width = 5,
   parameter int DATA_WIDTH = 32,
   localparam int BRB_N = brb_bits_f(wire_width, fpga_width),
   localparam int BSB_N = bsb_bits_f(wire_width, fpga_width),
   localparam int LB_N  = lb_bits_f(fpga_width)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   fpga_row_cfg_loader_if.slave    cfg,
   output logic                    busy,
   output logic                    cfg_done,
   output logic                    cfg_err,
   output logic [BRB_N-1:0]        brbselect,
   output logic [BSB_N-1:0]        bsbselect,
   output logic [LB_N-1:0]         lbselect
);

   localparam int CFG_N = BRB_N + BSB_N + LB_N;
   localparam int NW    = nwords_f(wire_width, fpga_width, DATA_WIDTH);
   localparam int CNT_W = (NW > 1) ? $clog2(NW + 1) : 1;

   cfg_state_t             state, state_nxt;
   logic [CNT_W-1:0]       word_cnt;
   logic [CFG_N-1:0]       shadow, shadow_nxt;
   logic [DATA_WIDTH-1:0]  acc;

   logic begin_load, load_beat, check_fail, commit;

   cfg_xor_accum #(.WIDTH(DATA_WIDTH)) u_accum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (begin_load),
      .en    (load_beat),
      .d     (cfg.in_data),
      .acc   (acc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // abort is checked before the beat so a simultaneous word is never counted.
   always_comb begin
      state_nxt    = state;
      cfg.in_ready = 1'b0;
      busy         = 1'b0;
      begin_load   = 1'b0;
      load_beat    = 1'b0;
      check_fail   = 1'b0;
      commit       = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               begin_load = 1'b1;
               state_nxt  = S_LOAD;
            end
         end
         S_LOAD: begin
            cfg.in_ready = 1'b1;
            busy         = 1'b1;
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (cfg.in_valid) begin
               load_beat = 1'b1;
               if (word_cnt == CNT_W'(NW - 1)) begin
                  state_nxt = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            cfg.in_ready = 1'b1;
            busy         = 1'b1;
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (cfg.in_valid) begin
               if (cfg.in_data == acc) begin
                  state_nxt = S_COMMIT;
               end else begin
                  check_fail = 1'b1;
                  state_nxt  = S_ERROR;
               end
            end
         end
         S_COMMIT: begin
            busy      = 1'b1;
            commit    = 1'b1;
            state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Word k lands at bit k*DATA_WIDTH; shifting within a CFG_N-wide vector
   // drops the unused upper bits of the final word automatically.
   always_comb begin
      logic [CFG_N-1:0] wmask;
      logic [CFG_N-1:0] wdata;
      int               shamt;
      shamt      = int'(word_cnt) * DATA_WIDTH;
      wmask      = CFG_N'({DATA_WIDTH{1'b1}}) << shamt;
      wdata      = CFG_N'(cfg.in_data) << shamt;
      shadow_nxt = (shadow & ~wmask) | (wdata & wmask);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_cnt  <= '0;
         shadow    <= '0;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         brbselect <= '0;
         bsbselect <= '0;
         lbselect  <= '0;
      end else begin
         cfg_done <= commit;
         if (begin_load) begin
            word_cnt <= '0;
            cfg_err  <= 1'b0;
         end
         if (load_beat) begin
            word_cnt <= word_cnt + CNT_W'(1);
            shadow   <= shadow_nxt;
         end
         if (check_fail) begin
            cfg_err <= 1'b1;
         end
         if (commit) begin
            {lbselect, bsbselect, brbselect} <= shadow;
         end
      end
   end

endmodule
